// File: rtl/bs_exp_pkg.sv
// Shared widths, constants and FSM encoding for the exp(-x) table front end.
package bs_exp_pkg;

  localparam int EXP_ADDR_W   = 10;
  localparam int EXP_LAST_IDX = 512;
  localparam int EXP_FRAC_W   = 6;
  localparam int EXP_X_W      = 16;
  localparam int EXP_Y_W      = 16;
  localparam int EXP_D_W      = EXP_Y_W + EXP_FRAC_W + 1;

  localparam logic [EXP_Y_W-1:0] EXP_ONE = 16'h4000;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    MUL,
    OUT
  } exp_state_t;

endpackage

// File: rtl/exp_interp_mac.sv
// Registered interpolation term d = (y0 - y1) * f + 32; d[22:6] is the rounded
// correction subtracted from y0. Instantiated only when EXP_NEG_INTERP_EN is defined.
module exp_interp_mac
  import bs_exp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [EXP_Y_W-1:0]    y0,
  input  logic [EXP_Y_W-1:0]    y1,
  input  logic [EXP_FRAC_W-1:0] f,
  output logic [EXP_D_W-1:0]    d
);

  // The table is monotonic decreasing, so y0 - y1 never wraps.
  logic [EXP_Y_W-1:0] diff;
  assign diff = y0 - y1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d <= '0;
    end else if (load) begin
      d <= EXP_D_W'(diff) * EXP_D_W'(f) + EXP_D_W'(32);
    end
  end

endmodule

// File: rtl/exp_neg_interp.sv
// exp(-x) table front end: Q4.12 argument in, Q2.14 result out over valid/ready.
// Define EXP_NEG_INTERP_EN for linear interpolation; otherwise nearest-entry lookup.
module exp_neg_interp
  import bs_exp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_X_W-1:0]    x_in,
  output logic [EXP_ADDR_W-1:0] rom_addr,
  input  logic [EXP_Y_W-1:0]    rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_Y_W-1:0]    y_out
);

  localparam logic [EXP_ADDR_W-1:0] LAST_ADDR = EXP_ADDR_W'(EXP_LAST_IDX);

  exp_state_t            state, state_next;
  logic [EXP_ADDR_W-1:0] idx, idx_in;

`ifdef EXP_NEG_INTERP_EN
  logic [EXP_FRAC_W-1:0] f, f_in;
  logic [EXP_Y_W-1:0]    y0;
  logic [EXP_D_W-1:0]    d;

  // x >= 8.0 pins to the last entry with no fractional step.
  always_comb begin
    if (x_in[15]) begin
      idx_in = LAST_ADDR;
      f_in   = '0;
    end else begin
      idx_in = {1'b0, x_in[14:6]};
      f_in   = x_in[5:0];
    end
  end

  exp_interp_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == RD1),
    .y0    (y0),
    .y1    (rom_data),
    .f     (f),
    .d     (d)
  );
`else
  logic unused_frac;
  assign unused_frac = ^x_in[4:0];

  // Round to nearest entry; idx <= 511 here, so idx + 1 never passes the last entry.
  always_comb begin
    if (x_in[15]) begin
      idx_in = LAST_ADDR;
    end else begin
      idx_in = {1'b0, x_in[14:6]} + {{(EXP_ADDR_W-1){1'b0}}, x_in[5]};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      y_out <= '0;
`ifdef EXP_NEG_INTERP_EN
      f     <= '0;
      y0    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state <= state_next;
      case (state)
        IDLE: if (in_valid) begin
          idx <= idx_in;
`ifdef EXP_NEG_INTERP_EN
          f   <= f_in;
`endif
        end
`ifdef EXP_NEG_INTERP_EN
        RD0: y0    <= rom_data;
        MUL: y_out <= y0 - EXP_Y_W'(d[EXP_D_W-1:EXP_FRAC_W]);
`else
        RD0: y_out <= rom_data;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rom_addr   = '0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) state_next = RD0;
      end
      RD0: begin
        rom_addr = idx;
`ifdef EXP_NEG_INTERP_EN
        state_next = RD1;
`else
        state_next = OUT;
`endif
      end
`ifdef EXP_NEG_INTERP_EN
      RD1: begin
        rom_addr   = (idx == LAST_ADDR) ? LAST_ADDR : idx + 1'b1;
        state_next = MUL;
      end
      MUL: state_next = OUT;
`endif
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
